// File: rtl/rtc_multi_alarm_if.sv
// Control, time-set, alarm-write and status bus of the multi-alarm RTC.
// The master drives control inputs; the slave (the RTC core) returns time and alarm status.
interface rtc_multi_alarm_if #(
    parameter int NUM_ALARMS = 4
);
    localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    // Single-cycle strobes: set_valid and alarm_wr act in the cycle they are high.
    // There is no ready; a rejected strobe is reported by set_err one cycle later.
    logic                    run;
    logic                    set_valid;
    logic [4:0]              set_hour;
    logic [5:0]              set_min;
    logic [5:0]              set_sec;
    logic                    set_err;
    logic                    alarm_wr;
    logic [IDX_W-1:0]        alarm_idx;
    logic [4:0]              alarm_hour;
    logic [5:0]              alarm_min;
    logic                    alarm_en;
    logic                    ack;
    logic                    snooze;
    logic                    mode_12h;
    logic [5:0]              sec;
    logic [5:0]              min;
    logic [4:0]              hour;
    logic                    pm;
    logic                    sec_pulse;
    logic [NUM_ALARMS-1:0]   alarm_active;
    logic                    ringing;
    logic [2*NUM_ALARMS-1:0] alarm_state_dbg;

    modport master (
        output run, set_valid, set_hour, set_min, set_sec,
        output alarm_wr, alarm_idx, alarm_hour, alarm_min, alarm_en,
        output ack, snooze, mode_12h,
        input  set_err, sec, min, hour, pm, sec_pulse, alarm_active, ringing, alarm_state_dbg
    );

    modport slave (
        input  run, set_valid, set_hour, set_min, set_sec,
        input  alarm_wr, alarm_idx, alarm_hour, alarm_min, alarm_en,
        input  ack, snooze, mode_12h,
        output set_err, sec, min, hour, pm, sec_pulse, alarm_active, ringing, alarm_state_dbg
    );
endinterface

// File: rtl/rtc_multi_alarm.sv
// Real-time clock with 1 Hz prescaler, validated time set, 12/24-hour display
// and NUM_ALARMS independent alarm channels with ring/snooze state machines.
module rtc_multi_alarm #(
    parameter int CLK_HZ     = 100000000,
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic             clk,
    input  logic             reset,
    rtc_multi_alarm_if.slave bus
);
    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SNZ_W = $clog2(SNOOZE_MIN * 60 + 1);
    localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_MIN * 60);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RING = 2'd1, ST_SNOOZE = 2'd2} alarm_state_e;

    logic [PRE_W-1:0] pre_q;
    logic [5:0]       sec_q, min_q, sec_d, min_d;
    logic [4:0]       hour_q, hour_d;
    logic             sec_pulse_q, set_err_q;

    logic [4:0]             al_hour_q  [NUM_ALARMS];
    logic [5:0]             al_min_q   [NUM_ALARMS];
    logic [NUM_ALARMS-1:0]  al_en_q;
    alarm_state_e           st_q       [NUM_ALARMS];
    logic [7:0]             ring_cnt_q [NUM_ALARMS];
    logic [SNZ_W-1:0]       snz_cnt_q  [NUM_ALARMS];

    logic tick, set_ok, wr_ok, set_load, wr_load;

    assign tick     = bus.run && (pre_q == PRE_W'(CLK_HZ - 1));
    assign set_ok   = (bus.set_hour < 5'd24) && (bus.set_min < 6'd60) && (bus.set_sec < 6'd60);
    assign wr_ok    = (bus.alarm_hour < 5'd24) && (bus.alarm_min < 6'd60)
                      && (int'(bus.alarm_idx) < NUM_ALARMS);
    assign set_load = bus.set_valid && set_ok;
    assign wr_load  = bus.alarm_wr && wr_ok;

    always_comb begin
        sec_d  = sec_q + 6'd1;
        min_d  = min_q;
        hour_d = hour_q;
        if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
                min_d  = 6'd0;
                hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
                min_d = min_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_q       <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            sec_pulse_q <= 1'b0;
            set_err_q   <= 1'b0;
            al_en_q     <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                al_hour_q[i]  <= '0;
                al_min_q[i]   <= '0;
                st_q[i]       <= ST_IDLE;
                ring_cnt_q[i] <= '0;
                snz_cnt_q[i]  <= '0;
            end
        end else begin
            set_err_q   <= (bus.set_valid && !set_ok) || (bus.alarm_wr && !wr_ok);
            // A valid set overrides a coincident tick, so it never yields a pulse.
            sec_pulse_q <= tick && !set_load;

            if (set_load) begin
                pre_q  <= '0;
                sec_q  <= bus.set_sec;
                min_q  <= bus.set_min;
                hour_q <= bus.set_hour;
            end else if (tick) begin
                pre_q  <= '0;
                sec_q  <= sec_d;
                min_q  <= min_d;
                hour_q <= hour_d;
            end else if (bus.run) begin
                pre_q <= pre_q + PRE_W'(1);
            end

            // Channel timers step on sec_pulse, so they freeze whenever run is low.
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (wr_load && int'(bus.alarm_idx) == i) begin
                    al_hour_q[i] <= bus.alarm_hour;
                    al_min_q[i]  <= bus.alarm_min;
                    al_en_q[i]   <= bus.alarm_en;
                    st_q[i]      <= ST_IDLE;
                end else begin
                    case (st_q[i])
                        ST_IDLE: begin
                            if (al_en_q[i] && sec_pulse_q && hour_q == al_hour_q[i]
                                && min_q == al_min_q[i] && sec_q == 6'd0) begin
                                st_q[i]       <= ST_RING;
                                ring_cnt_q[i] <= '0;
                            end
                        end
                        ST_RING: begin
                            if (bus.ack) begin
                                st_q[i] <= ST_IDLE;
                            end else if (bus.snooze) begin
                                st_q[i]      <= ST_SNOOZE;
                                snz_cnt_q[i] <= SNZ_LOAD;
                            end else if (sec_pulse_q) begin
                                if (ring_cnt_q[i] == 8'(RING_SEC - 1)) st_q[i] <= ST_IDLE;
                                else ring_cnt_q[i] <= ring_cnt_q[i] + 8'd1;
                            end
                        end
                        ST_SNOOZE: begin
                            if (bus.ack) begin
                                st_q[i] <= ST_IDLE;
                            end else if (sec_pulse_q) begin
                                if (snz_cnt_q[i] <= SNZ_W'(1)) begin
                                    st_q[i]       <= ST_RING;
                                    ring_cnt_q[i] <= '0;
                                end else begin
                                    snz_cnt_q[i] <= snz_cnt_q[i] - SNZ_W'(1);
                                end
                            end
                        end
                        default: st_q[i] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    always_comb begin
        bus.pm   = (hour_q >= 5'd12);
        bus.hour = hour_q;
        if (bus.mode_12h) begin
            if (hour_q == 5'd0)       bus.hour = 5'd12;
            else if (hour_q > 5'd12)  bus.hour = hour_q - 5'd12;
        end
    end

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_status
        assign bus.alarm_active[g]            = (st_q[g] == ST_RING);
        assign bus.alarm_state_dbg[2*g +: 2]  = st_q[g];
    end

    assign bus.ringing   = |bus.alarm_active;
    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.set_err   = set_err_q;
endmodule

// File: tb/tb_rtc_multi_alarm.sv
// Directed bench for rtc_multi_alarm with a 4-cycle second, 1-minute snooze
// and 3-second ring timeout.
module tb_rtc_multi_alarm;
    logic clk;
    logic reset;
    int   total;
    int   passed;
    int   failed;

    rtc_multi_alarm_if #(.NUM_ALARMS(4)) bus ();

    rtc_multi_alarm #(
        .CLK_HZ    (4),
        .NUM_ALARMS(4),
        .SNOOZE_MIN(1),
        .RING_SEC  (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_set(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.set_hour  = h;
        bus.set_min   = m;
        bus.set_sec   = s;
        bus.set_valid = 1'b1;
        step(1);
        bus.set_valid = 1'b0;
    endtask

    task automatic do_alarm(input logic [1:0] idx, input logic [4:0] h, input logic [5:0] m,
                            input logic en);
        bus.alarm_idx  = idx;
        bus.alarm_hour = h;
        bus.alarm_min  = m;
        bus.alarm_en   = en;
        bus.alarm_wr   = 1'b1;
        step(1);
        bus.alarm_wr   = 1'b0;
    endtask

    task automatic chk_time(input string tag, input logic [4:0] h, input logic [5:0] m,
                            input logic [5:0] s);
        chk({tag, "_hour"}, 32'(bus.hour), 32'(h));
        chk({tag, "_min"},  32'(bus.min),  32'(m));
        chk({tag, "_sec"},  32'(bus.sec),  32'(s));
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        reset  = 1'b0;
        bus.run = 1'b0;  bus.set_valid = 1'b0; bus.set_hour = '0; bus.set_min = '0;
        bus.set_sec = '0; bus.alarm_wr = 1'b0; bus.alarm_idx = '0; bus.alarm_hour = '0;
        bus.alarm_min = '0; bus.alarm_en = 1'b0; bus.ack = 1'b0; bus.snooze = 1'b0;
        bus.mode_12h = 1'b0;
        step(2);
        reset = 1'b1;

        // Reset state
        chk_time("rst", 5'd0, 6'd0, 6'd0);
        chk("rst_pm", 32'(bus.pm), 0);
        chk("rst_pulse", 32'(bus.sec_pulse), 0);
        chk("rst_err", 32'(bus.set_err), 0);
        chk("rst_ringing", 32'(bus.ringing), 0);
        chk("rst_state", 32'(bus.alarm_state_dbg), 0);
        bus.mode_12h = 1'b1;
        #1;
        chk("rst_hour12", 32'(bus.hour), 12);
        bus.mode_12h = 1'b0;

        // Prescaler and pulse cadence
        bus.run = 1'b1;
        step(3);
        chk("pre_sec0", 32'(bus.sec), 0);
        chk("pre_pulse0", 32'(bus.sec_pulse), 0);
        step(1);
        chk("pre_sec1", 32'(bus.sec), 1);
        chk("pre_pulse1", 32'(bus.sec_pulse), 1);
        step(1);
        chk("pre_pulse_narrow", 32'(bus.sec_pulse), 0);
        step(3);
        chk("pre_sec2", 32'(bus.sec), 2);
        chk("pre_pulse2", 32'(bus.sec_pulse), 1);
        step(2);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk_time("midrst", 5'd0, 6'd0, 6'd0);

        // Day wrap, rejected set, set beating a tick
        bus.run = 1'b0;
        do_set(5'd23, 6'd59, 6'd59);
        chk_time("set235959", 5'd23, 6'd59, 6'd59);
        chk("set_pm", 32'(bus.pm), 1);
        chk("set_err_ok", 32'(bus.set_err), 0);
        bus.run = 1'b1;
        step(3);
        chk("wrap_hold", 32'(bus.sec), 59);
        step(1);
        chk_time("wrap", 5'd0, 6'd0, 6'd0);
        chk("wrap_pm", 32'(bus.pm), 0);
        bus.run = 1'b0;
        do_set(5'd24, 6'd0, 6'd0);
        chk("bad_set_err", 32'(bus.set_err), 1);
        chk_time("bad_set", 5'd0, 6'd0, 6'd0);
        step(1);
        chk("bad_set_err_end", 32'(bus.set_err), 0);
        do_set(5'd10, 6'd20, 6'd30);
        bus.run = 1'b1;
        step(3);
        do_set(5'd11, 6'd22, 6'd33);
        chk_time("set_vs_tick", 5'd11, 6'd22, 6'd33);
        chk("set_vs_tick_pulse", 32'(bus.sec_pulse), 0);
        step(3);
        chk("after_set_hold", 32'(bus.sec), 33);
        step(1);
        chk("after_set_tick", 32'(bus.sec), 34);

        // Alarm trigger latency, ack, and no trigger from a direct set
        bus.run = 1'b0;
        do_alarm(2'd0, 5'd7, 6'd30, 1'b1);
        chk("alarm_wr_err", 32'(bus.set_err), 0);
        do_set(5'd7, 6'd29, 6'd59);
        bus.run = 1'b1;
        step(4);
        chk_time("al0_hit", 5'd7, 6'd30, 6'd0);
        chk("al0_not_yet", 32'(bus.alarm_active), 0);
        step(1);
        chk("al0_ring", 32'(bus.alarm_active), 32'h1);
        chk("al0_ringing", 32'(bus.ringing), 1);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        chk("al0_ack", 32'(bus.alarm_active), 0);
        bus.run = 1'b0;
        do_set(5'd7, 6'd30, 6'd0);
        step(2);
        chk("al0_direct_set", 32'(bus.alarm_active), 0);
        bus.run = 1'b1;
        step(5);
        chk("al0_direct_set_tick", 32'(bus.alarm_active), 0);
        bus.run = 1'b0;
        do_alarm(2'd0, 5'd7, 6'd30, 1'b0);
        do_alarm(2'd3, 5'd24, 6'd0, 1'b1);
        chk("alarm_bad_err", 32'(bus.set_err), 1);

        // Snooze, re-ring after 60 seconds, ring timeout, ack beating snooze
        do_alarm(2'd3, 5'd8, 6'd0, 1'b1);
        do_set(5'd7, 6'd59, 6'd59);
        bus.run = 1'b1;
        step(5);
        chk("al3_ring", 32'(bus.alarm_active), 32'h8);
        bus.snooze = 1'b1;
        step(1);
        bus.snooze = 1'b0;
        chk("al3_snoozed", 32'(bus.alarm_active), 0);
        chk("al3_state_snooze", 32'(bus.alarm_state_dbg[7:6]), 2);
        step(238);
        chk("snooze_silent", 32'(bus.alarm_active), 0);
        chk_time("snooze_end", 5'd8, 6'd1, 6'd0);
        step(1);
        chk("snooze_rering", 32'(bus.alarm_active), 32'h8);
        step(11);
        chk("ring_before_to", 32'(bus.alarm_active), 32'h8);
        step(1);
        chk("ring_timeout", 32'(bus.alarm_active), 0);
        chk("ring_timeout_state", 32'(bus.alarm_state_dbg[7:6]), 0);
        do_set(5'd7, 6'd59, 6'd59);
        step(5);
        chk("al3_ring2", 32'(bus.alarm_active), 32'h8);
        bus.ack = 1'b1;
        bus.snooze = 1'b1;
        step(1);
        bus.ack = 1'b0;
        bus.snooze = 1'b0;
        chk("ack_wins", 32'(bus.alarm_state_dbg[7:6]), 0);
        bus.run = 1'b0;
        do_alarm(2'd3, 5'd8, 6'd0, 1'b0);

        // Two channels ringing together; rewriting one silences only it; reset clears ring
        do_alarm(2'd1, 5'd6, 6'd0, 1'b1);
        do_alarm(2'd2, 5'd6, 6'd0, 1'b1);
        do_set(5'd5, 6'd59, 6'd59);
        bus.run = 1'b1;
        step(5);
        chk("dual_ring", 32'(bus.alarm_active), 32'h6);
        chk("dual_ringing", 32'(bus.ringing), 1);
        do_alarm(2'd1, 5'd6, 6'd0, 1'b1);
        chk("rewrite_ch1", 32'(bus.alarm_active), 32'h4);
        chk("rewrite_ringing", 32'(bus.ringing), 1);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk("reset_ring", 32'(bus.ringing), 0);
        chk("reset_ring_state", 32'(bus.alarm_state_dbg), 0);
        chk_time("reset_ring", 5'd0, 6'd0, 6'd0);

        // 12-hour display mapping
        bus.run = 1'b0;
        bus.mode_12h = 1'b1;
        do_set(5'd0, 6'd15, 6'd45);
        chk("h12_0", 32'(bus.hour), 12);
        chk("h12_0_pm", 32'(bus.pm), 0);
        do_set(5'd12, 6'd15, 6'd45);
        chk("h12_12", 32'(bus.hour), 12);
        chk("h12_12_pm", 32'(bus.pm), 1);
        do_set(5'd13, 6'd15, 6'd45);
        chk("h12_13", 32'(bus.hour), 1);
        chk("h12_13_pm", 32'(bus.pm), 1);
        do_set(5'd23, 6'd15, 6'd45);
        chk("h12_23", 32'(bus.hour), 11);
        chk("h12_23_pm", 32'(bus.pm), 1);
        bus.mode_12h = 1'b0;
        #1;
        chk_time("h24_back", 5'd23, 6'd15, 6'd45);
        bus.mode_12h = 1'b1;
        #1;
        chk_time("h12_again", 5'd11, 6'd15, 6'd45);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
